alu_writeback: RTL and testbench

Writeback stage directly downstream of the 16-bit ALU. Captures each ALU result with its destination register address, holds it in a 2-entry buffer, and presents it to the register-file write port under a valid/ready handshake. Also owns the architectural status flags (carry, zero, negative), and feeds the carry flag back to the ALU carry input.

---
 rtl/alu_writeback.sv | 120 ++++++++++++
 tb/tb_alu_writeback.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry result buffer feeding the register-file write port,
// plus the carry/zero/negative status flags. Define ALU_WB_FWD_EN to add forwarding outputs.
module alu_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c_out,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              flag_we,
  input  logic              flags_clr,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              neg_flag,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        occupancy
`ifdef ALU_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  logic accept, push, pop;

  always_comb begin
    in_ready  = (count_q != 2'd2);
    wb_valid  = (count_q != 2'd0);
    accept    = in_valid && in_ready;
    // Writes to r0 are discarded but still count as accepted for the flags.
    push      = accept && (dest_addr != '0);
    pop       = wb_valid && wb_ready;

    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[tail_q] = dest_addr;
      data_d[tail_q] = alu_out;
    end
    head_d = head_q ^ pop;
    tail_d = tail_q ^ push;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (flags_clr) begin
      carry_d = 1'b0;
      zero_d  = 1'b0;
      neg_d   = 1'b0;
    end else if (accept && flag_we) begin
      carry_d = alu_c_out;
      zero_d  = (alu_out == '0);
      neg_d   = alu_out[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign wb_addr    = addr_q[head_q];
  assign wb_data    = data_q[head_q];
  assign occupancy  = count_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;

`ifdef ALU_WB_FWD_EN
  // Newest live entry sits one slot behind the tail pointer.
  assign fwd_valid = (count_q != 2'd0);
  assign fwd_addr  = addr_q[~tail_q];
  assign fwd_data  = data_q[~tail_q];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_writeback;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] alu_out = '0;
  logic          alu_c_out = 1'b0;
  logic [AW-1:0] dest_addr = '0;
  logic          flag_we = 1'b0;
  logic          flags_clr = 1'b0;
  logic          carry_flag, zero_flag, neg_flag;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [1:0]    occupancy;
`ifdef ALU_WB_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
`endif

  alu_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_c_out(alu_c_out), .dest_addr(dest_addr),
    .flag_we(flag_we), .flags_clr(flags_clr),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .occupancy(occupancy)
`ifdef ALU_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending writes plus three flag bits.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t m_q[$];
  logic m_c = 1'b0, m_z = 1'b0, m_n = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    end else begin
      bit acc, popped;
      acc    = in_valid && (m_q.size() < 2);
      popped = (m_q.size() != 0) && wb_ready;
      if (popped) void'(m_q.pop_front());
      if (acc && dest_addr != 0) m_q.push_back('{a: dest_addr, d: alu_out});
      if (flags_clr) begin
        m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
      end else if (acc && flag_we) begin
        m_c = alu_c_out;
        m_z = (alu_out == 0);
        m_n = alu_out[DW-1];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_in_ready",  32'(in_ready),   32'(m_q.size() < 2));
      chk("m_wb_valid",  32'(wb_valid),   32'(m_q.size() != 0));
      chk("m_occupancy", 32'(occupancy),  32'(m_q.size()));
      chk("m_carry",     32'(carry_flag), 32'(m_c));
      chk("m_zero",      32'(zero_flag),  32'(m_z));
      chk("m_neg",       32'(neg_flag),   32'(m_n));
      if (m_q.size() != 0) begin
        chk("m_wb_addr", 32'(wb_addr), 32'(m_q[0].a));
        chk("m_wb_data", 32'(wb_data), 32'(m_q[0].d));
      end
`ifdef ALU_WB_FWD_EN
      chk("m_fwd_valid", 32'(fwd_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("m_fwd_addr", 32'(fwd_addr), 32'(m_q[m_q.size()-1].a));
        chk("m_fwd_data", 32'(fwd_data), 32'(m_q[m_q.size()-1].d));
      end
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic c,
                       input logic [AW-1:0] a, input logic fw);
    in_valid = v; alu_out = d; alu_c_out = c; dest_addr = a; flag_we = fw;
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    mon_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_occ",      32'(occupancy), 32'd0);
    chk("rst_wb_addr",  32'(wb_addr), 32'd0);
    chk("rst_wb_data",  32'(wb_data), 32'd0);
    chk("rst_flags",    32'({carry_flag, zero_flag, neg_flag}), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single result
    drive(1'b1, 16'h0000, 1'b1, 4'd3, 1'b1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("one_valid", 32'(wb_valid), 32'd1);
    chk("one_addr",  32'(wb_addr), 32'd3);
    chk("one_data",  32'(wb_data), 32'h0000);
    chk("one_flags", 32'({carry_flag, zero_flag, neg_flag}), 32'b110);
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    chk("one_drained", 32'(occupancy), 32'd0);

    // Backpressure
    drive(1'b1, 16'h8001, 1'b0, 4'd1, 1'b0);
    cyc();
    drive(1'b1, 16'h0002, 1'b0, 4'd2, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("bp_occ",   32'(occupancy), 32'd2);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_head",  32'({wb_addr, wb_data}), 32'h1_8001);
    cyc();
    chk("bp_stable", 32'({wb_addr, wb_data}), 32'h1_8001);
    wb_ready = 1'b1;
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    chk("bp_pop1_head",  32'({wb_addr, wb_data}), 32'h2_0002);
    cyc();
    chk("bp_empty", 32'(wb_valid), 32'd0);

    // Streaming 1..8 to r1..r8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b0, AW'(i), 1'b1);
      cyc();
      chk("st_ready", 32'(in_ready), 32'd1);
      chk("st_occ",   32'(occupancy), 32'd1);
      chk("st_head",  32'({wb_addr, wb_data}), (32'(i) << 16) | 32'(i));
    end
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    cyc();
    chk("st_done", 32'(occupancy), 32'd0);

    // r0 drop
    drive(1'b1, 16'hFFFF, 1'b0, 4'd0, 1'b1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("r0_valid", 32'(wb_valid), 32'd0);
    chk("r0_occ",   32'(occupancy), 32'd0);
    chk("r0_flags", 32'({carry_flag, zero_flag, neg_flag}), 32'b001);

    // Flag clear priority, data still enqueued
    wb_ready = 1'b0;
    drive(1'b1, 16'h8000, 1'b1, 4'd5, 1'b1);
    flags_clr = 1'b1;
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    flags_clr = 1'b0;
    chk("clr_flags", 32'({carry_flag, zero_flag, neg_flag}), 32'd0);
    chk("clr_head",  32'({wb_valid, wb_addr, wb_data}), 32'h1_5_8000);

    // Reset mid-stream with two entries buffered
    drive(1'b1, 16'h1234, 1'b1, 4'd7, 1'b1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("pre_rst_occ",   32'(occupancy), 32'd2);
    chk("pre_rst_carry", 32'(carry_flag), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(wb_valid), 32'd0);
    chk("arst_occ",   32'(occupancy), 32'd0);
    chk("arst_flags", 32'({carry_flag, zero_flag, neg_flag}), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    wb_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_valid", 32'(wb_valid), 32'd0);
    cyc();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
